// File: rtl/bnn_window_feeder_pkg.sv
// Shared constants and types for the BNN VAD window feeder (package bnn_pkg).
package bnn_pkg;

  localparam int DATA_W    = 16;
  localparam int TAPS      = 5;
  localparam int FRAME_LEN = 20;
  localparam int FRAMES    = 6;

  localparam int WIN_PER_FRAME = FRAME_LEN - TAPS + 1;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SAMP_W = cnt_w(FRAME_LEN);
  localparam int FRM_W  = cnt_w(FRAMES);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } feed_state_e;

endpackage

// File: rtl/bnn_window_feeder_if.sv
// Sample input stream and packed window output stream of the BNN window feeder.
interface bnn_window_feeder_if #(
  parameter int DATA_W    = bnn_pkg::DATA_W,
  parameter int TAPS      = bnn_pkg::TAPS,
  parameter int FRAME_LEN = bnn_pkg::FRAME_LEN,
  parameter int FRAMES    = bnn_pkg::FRAMES
);
  import bnn_pkg::*;

  localparam int POS_W = cnt_w(FRAME_LEN);
  localparam int FRM_W = cnt_w(FRAMES);

  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic                     win_valid;
  logic                     win_ready;
  logic [TAPS*DATA_W-1:0]   win_data;
  logic [FRM_W-1:0]         win_frame;
  logic [POS_W-1:0]         win_pos;
  logic                     win_last;

  modport master (
    output s_valid, s_data, win_ready,
    input  s_ready, win_valid, win_data, win_frame, win_pos, win_last
  );

  modport slave (
    input  s_valid, s_data, win_ready,
    output s_ready, win_valid, win_data, win_frame, win_pos, win_last
  );

endinterface

// File: rtl/bnn_window_feeder_tap_shreg.sv
// Tap history for the window feeder: DEPTH-entry shift register, entry 0 oldest.
module bnn_tap_shreg #(
  parameter int DEPTH = bnn_pkg::TAPS - 1,
  parameter int WIDTH = bnn_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       din,
  output logic [DEPTH*WIDTH-1:0] taps
);

  logic [DEPTH*WIDTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clr) begin
      taps_d = '0;
    end else if (shift_en) begin
      taps_d = {din, taps_q[DEPTH*WIDTH-1:WIDTH]};
    end
  end

  // NOTE: the history is only a few words, so it takes the async reset like any other
  // flop; a reset mid-frame must never leak stale samples into the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taps_q <= '0;
    else        taps_q <= taps_d;
  end

  assign taps = taps_q;

endmodule

// File: rtl/bnn_window_feeder.sv
// Streams samples into stride-1 TAPS-wide windows per frame, tracking frame/segment position.
// Define BNN_FEED_BINARIZE_EN to sign-binarize each tap (+1 / -1) before it leaves the block.
module bnn_window_feeder #(
  parameter int DATA_W    = bnn_pkg::DATA_W,
  parameter int TAPS      = bnn_pkg::TAPS,
  parameter int FRAME_LEN = bnn_pkg::FRAME_LEN,
  parameter int FRAMES    = bnn_pkg::FRAMES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  bnn_window_feeder_if.slave  bus,
  output logic                seg_done
);
  import bnn_pkg::*;

  localparam int SAMP_W = cnt_w(FRAME_LEN);
  localparam int FRM_W  = cnt_w(FRAMES);
  localparam int WIN_W  = TAPS * DATA_W;

  localparam logic [SAMP_W-1:0] FILL_END  = SAMP_W'(TAPS - 2);
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(FRAME_LEN - 1);
  localparam logic [SAMP_W-1:0] POS_OFS   = SAMP_W'(TAPS - 1);
  localparam logic [FRM_W-1:0]  LAST_FRM  = FRM_W'(FRAMES - 1);

  feed_state_e         state_q,     state_d;
  logic [SAMP_W-1:0]   samp_cnt_q,  samp_cnt_d;
  logic [FRM_W-1:0]    frm_cnt_q,   frm_cnt_d;
  logic                win_valid_q, win_valid_d;
  logic [WIN_W-1:0]    win_data_q,  win_data_d;
  logic [FRM_W-1:0]    win_frame_q, win_frame_d;
  logic [SAMP_W-1:0]   win_pos_q,   win_pos_d;
  logic                win_last_q,  win_last_d;
  logic                seg_done_q,  seg_done_d;

  logic [(TAPS-1)*DATA_W-1:0] taps;
  logic [WIN_W-1:0]           win_load;
  logic                       s_ready, s_acc, win_hs, frame_end;

  // Flush blocks intake; FILL never produces a window, so it never waits on the consumer.
  assign s_ready   = !flush && (state_q == FILL || !win_valid_q || bus.win_ready);
  assign s_acc     = bus.s_valid && s_ready;
  assign win_hs    = win_valid_q && bus.win_ready;
  assign frame_end = s_acc && (samp_cnt_q == LAST_SAMP);

  bnn_tap_shreg #(
    .DEPTH (TAPS - 1),
    .WIDTH (DATA_W)
  ) u_taps (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush || frame_end),
    .shift_en (s_acc),
    .din      (bus.s_data),
    .taps     (taps)
  );

  always_comb begin
    win_load = {bus.s_data, taps};
`ifdef BNN_FEED_BINARIZE_EN
    for (int k = 0; k < TAPS; k++) begin
      win_load[k*DATA_W +: DATA_W] = win_load[k*DATA_W + DATA_W - 1] ? {DATA_W{1'b1}}
                                                                      : DATA_W'(1);
    end
`endif
  end

  // NOTE: every *_d starts from its *_q so each path through the branches below
  // leaves a defined value and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_frame_d = win_frame_q;
    win_pos_d   = win_pos_q;
    win_last_d  = win_last_q;
    seg_done_d  = 1'b0;

    if (flush) begin
      state_d     = FILL;
      samp_cnt_d  = '0;
      frm_cnt_d   = '0;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else begin
      if (win_hs) begin
        win_valid_d = 1'b0;
        seg_done_d  = win_last_q;
      end
      if (s_acc) begin
        samp_cnt_d = samp_cnt_q + 1'b1;
        if (state_q == FILL) begin
          if (samp_cnt_q == FILL_END) state_d = RUN;
        end else begin
          win_valid_d = 1'b1;
          win_data_d  = win_load;
          win_frame_d = frm_cnt_q;
          win_pos_d   = samp_cnt_q - POS_OFS;
          win_last_d  = (frm_cnt_q == LAST_FRM) && (samp_cnt_q == LAST_SAMP);
        end
        if (frame_end) begin
          state_d    = FILL;
          samp_cnt_d = '0;
          frm_cnt_d  = (frm_cnt_q == LAST_FRM) ? '0 : frm_cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      samp_cnt_q  <= '0;
      frm_cnt_q   <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_frame_q <= '0;
      win_pos_q   <= '0;
      win_last_q  <= 1'b0;
      seg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_frame_q <= win_frame_d;
      win_pos_q   <= win_pos_d;
      win_last_q  <= win_last_d;
      seg_done_q  <= seg_done_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_frame = win_frame_q;
  assign bus.win_pos   = win_pos_q;
  assign bus.win_last  = win_last_q;
  assign seg_done      = seg_done_q;

endmodule

// File: tb/tb_bnn_window_feeder.sv
// Scoreboard bench for bnn_window_feeder: a frame-buffer model pushes expected windows
// on every accepted sample; a negedge monitor pops and compares on each window handshake.
module tb_bnn_window_feeder;
  import bnn_pkg::*;

  localparam int WIN_W = TAPS * DATA_W;

  typedef struct packed {
    logic [WIN_W-1:0]  data;
    logic [FRM_W-1:0]  frame;
    logic [SAMP_W-1:0] pos;
    logic              last;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic seg_done;

  bnn_window_feeder_if bus ();

  bnn_window_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .seg_done (seg_done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  win_t exp_q[$];
  win_t got_log[$];
  logic [DATA_W-1:0] fbuf [FRAME_LEN];
  int   m_pos, m_frm;
  int   n_win = 0, n_seg = 0, frame_wraps = 0, last_frame_seen = -1;
  logic seg_exp = 1'b0;
  logic prev_stall = 1'b0;
  win_t prev_w;

  function automatic logic [DATA_W-1:0] model_tap(input logic [DATA_W-1:0] s);
`ifdef BNN_FEED_BINARIZE_EN
    return s[DATA_W-1] ? DATA_W'(-1) : DATA_W'(1);
`else
    return s;
`endif
  endfunction

  function automatic logic [WIN_W-1:0] pack_win(input int first);
    logic [WIN_W-1:0] w;
    for (int k = 0; k < TAPS; k++) w[k*DATA_W +: DATA_W] = model_tap(DATA_W'(first + k));
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_pos = 0;
    m_frm = 0;
    seg_exp = 1'b0;
    prev_stall = 1'b0;
    last_frame_seen = -1;
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d);
    win_t w;
    fbuf[m_pos] = d;
    if (m_pos >= TAPS - 1) begin
      for (int k = 0; k < TAPS; k++)
        w.data[k*DATA_W +: DATA_W] = model_tap(fbuf[m_pos - (TAPS - 1) + k]);
      w.frame = FRM_W'(m_frm);
      w.pos   = SAMP_W'(m_pos - (TAPS - 1));
      w.last  = (m_frm == FRAMES - 1) && (m_pos == FRAME_LEN - 1);
      exp_q.push_back(w);
    end
    m_pos++;
    if (m_pos == FRAME_LEN) begin
      m_pos = 0;
      m_frm = (m_frm + 1) % FRAMES;
    end
  endtask

  always @(negedge clk) begin
    win_t got, w;
    logic exp_rdy;
    got = '{bus.win_data, bus.win_frame, bus.win_pos, bus.win_last};
    if (!rst_n) begin
      model_clear();
    end else if (flush) begin
      n_checks++;
      if (bus.s_ready !== 1'b0) $display("FAIL flush_s_ready: got %0b want 0", bus.s_ready);
      else n_pass++;
      n_checks++;
      if (seg_done !== seg_exp) $display("FAIL seg_done_flush: got %0b want %0b", seg_done, seg_exp);
      else n_pass++;
      if (seg_done === 1'b1) n_seg++;
      model_clear();
    end else begin
      n_checks++;
      if (seg_done !== seg_exp) $display("FAIL seg_done: got %0b want %0b", seg_done, seg_exp);
      else n_pass++;
      if (seg_done === 1'b1) n_seg++;
      seg_exp = 1'b0;

      n_checks++;
      if (bus.win_valid !== (exp_q.size() != 0))
        $display("FAIL win_valid: got %0b want %0b", bus.win_valid, exp_q.size() != 0);
      else n_pass++;

      if (prev_stall) begin
        n_checks++;
        if ({bus.win_valid, got} !== {1'b1, prev_w})
          $display("FAIL stall_hold: got %0b/%h want 1/%h", bus.win_valid, got, prev_w);
        else n_pass++;
      end
      prev_stall = bus.win_valid && !bus.win_ready;
      prev_w = got;

      exp_rdy = (m_pos < TAPS - 1) || (exp_q.size() == 0) || bus.win_ready;
      n_checks++;
      if (bus.s_ready !== exp_rdy) $display("FAIL s_ready: got %0b want %0b", bus.s_ready, exp_rdy);
      else n_pass++;

      if (bus.win_valid && bus.win_ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        n_checks++;
        if (got !== w) $display("FAIL window: got %h want %h", got, w);
        else n_pass++;
        got_log.push_back(got);
        n_win++;
        if (w.last) seg_exp = 1'b1;
        if (int'(w.frame) == 0 && last_frame_seen == FRAMES - 1) frame_wraps++;
        last_frame_seen = int'(w.frame);
      end

      if (bus.s_valid && bus.s_ready) model_accept(bus.s_data);
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    logic acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: sample %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic send_range(input int first, input int n, input int stall_after, input int stall_len);
    for (int i = 0; i < n; i++) begin
      send(DATA_W'(first + i));
      if (i == stall_after) begin
        bus.win_ready = 1'b0;
        bus.s_data    = DATA_W'(first + i + 1);
        repeat (stall_len) begin
          @(posedge clk);
          #1;
        end
        bus.win_ready = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.win_valid, bus.win_last, seg_done} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.win_valid, bus.win_last, seg_done});
    else n_pass++;
    n_checks++;
    if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %0b want 1", bus.s_ready);
    else n_pass++;
    n_checks++;
    if ({bus.win_data, bus.win_frame, bus.win_pos} !== '0)
      $display("FAIL reset_window: got %h want 0", {bus.win_data, bus.win_frame, bus.win_pos});
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_logged(input string name, input int idx, input win_t want);
    n_checks++;
    if (got_log.size() <= idx) $display("FAIL %s: got no window #%0d want %h", name, idx, want);
    else if (got_log[idx] !== want) $display("FAIL %s: got %h want %h", name, got_log[idx], want);
    else n_pass++;
  endtask

  task automatic test_stream(input string name, input int stall_after);
    int w0 = n_win, s0 = n_seg;
    got_log.delete();
    send_range(1, FRAMES * FRAME_LEN, stall_after, 5);
    idle(4);
    check_logged({name, "_first"}, 0, '{pack_win(1), 0, 0, 1'b0});
    check_logged({name, "_frame1"}, WIN_PER_FRAME, '{pack_win(21), 1, 0, 1'b0});
    check_logged({name, "_last"}, FRAMES * WIN_PER_FRAME - 1,
                 '{pack_win(116), FRM_W'(FRAMES - 1), SAMP_W'(FRAME_LEN - TAPS), 1'b1});
    n_checks++;
    if (n_win - w0 != FRAMES * WIN_PER_FRAME)
      $display("FAIL %s_count: got %0d want %0d", name, n_win - w0, FRAMES * WIN_PER_FRAME);
    else n_pass++;
    n_checks++;
    if (n_seg - s0 != 1) $display("FAIL %s_seg_done: got %0d want 1", name, n_seg - s0);
    else n_pass++;
  endtask

  task automatic test_flush();
    int s0 = n_seg;
    send_range(1, 2 * FRAME_LEN + 12, -1, 0);
    bus.win_ready = 1'b0;
    flush = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data = DATA_W'(999);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.win_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.win_valid !== 1'b0) $display("FAIL flush_drop: got %0b want 0", bus.win_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    got_log.delete();
    send_range(1001, TAPS, -1, 0);
    idle(3);
    check_logged("flush_restart", 0, '{pack_win(1001), 0, 0, 1'b0});
    n_checks++;
    if (n_seg != s0) $display("FAIL flush_seg_done: got %0d pulses want 0", n_seg - s0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0;
    bus.win_ready = 1'b0;
    send(DATA_W'(2000));
    n_checks++;
    if (bus.win_valid !== 1'b1) $display("FAIL rst_mid_pre: got %0b want 1", bus.win_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.win_valid, bus.win_last, seg_done, bus.win_data, bus.win_frame, bus.win_pos} !== '0)
      $display("FAIL rst_mid_outputs: got %h want 0",
               {bus.win_valid, bus.win_last, seg_done, bus.win_data, bus.win_frame, bus.win_pos});
    else n_pass++;
    n_checks++;
    if (bus.s_ready !== 1'b1) $display("FAIL rst_mid_s_ready: got %0b want 1", bus.s_ready);
    else n_pass++;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.win_ready = 1'b1;
    got_log.delete();
    w0 = n_win;
    send_range(3001, TAPS - 1, -1, 0);
    idle(3);
    n_checks++;
    if (n_win != w0) $display("FAIL rst_mid_early: got %0d windows want 0", n_win - w0);
    else n_pass++;
    send(DATA_W'(3001 + TAPS - 1));
    idle(3);
    check_logged("rst_mid_restart", 0, '{pack_win(3001), 0, 0, 1'b0});
  endtask

  task automatic test_back_to_back();
    int w0, s0, f0;
    apply_reset();
    w0 = n_win; s0 = n_seg; f0 = frame_wraps;
    send_range(1, 2 * FRAMES * FRAME_LEN, -1, 0);
    idle(4);
    n_checks++;
    if (n_seg - s0 != 2) $display("FAIL b2b_seg_done: got %0d want 2", n_seg - s0);
    else n_pass++;
    n_checks++;
    if (n_win - w0 != 2 * FRAMES * WIN_PER_FRAME)
      $display("FAIL b2b_count: got %0d want %0d", n_win - w0, 2 * FRAMES * WIN_PER_FRAME);
    else n_pass++;
    n_checks++;
    if (frame_wraps - f0 != 1) $display("FAIL b2b_wrap: got %0d want 1", frame_wraps - f0);
    else n_pass++;
  endtask

  task automatic test_binarize();
    logic [WIN_W-1:0] want;
`ifdef BNN_FEED_BINARIZE_EN
    want = {16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF};
`else
    want = {16'h0001, 16'h8000, 16'h0007, 16'h0000, 16'hFFFD};
`endif
    apply_reset();
    got_log.delete();
    send(16'hFFFD);
    send(16'h0000);
    send(16'h0007);
    send(16'h8000);
    send(16'h0001);
    idle(3);
    check_logged("binarize", 0, '{want, 0, 0, 1'b0});
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.win_ready = 1'b1;
    test_reset();
    test_stream("stream", -1);
    test_stream("backpressure", 30);
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_binarize();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
